// File: rtl/serial_shift_engine.sv
// Sequential shifter/rotator with a start/busy/done handshake, stepping Q under clock enable.
// Optional SERIAL_SHIFT_MULTISTEP_EN: non-serial modes advance up to four positions per cycle.
module serial_shift_engine #(
    parameter int WIDTH     = 8,
    parameter int AMT_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     D,
    input  logic                 start,
    input  logic [2:0]           mode,
    input  logic [AMT_WIDTH-1:0] amount,
    input  logic                 serial_in,
    input  logic                 abort,
    output logic [WIDTH-1:0]     Q,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done
);

    // state   | meaning
    // ST_IDLE | waiting for load/start; done pulses here after an op completes
    // ST_RUN  | stepping Q, count holds positions still to go
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    typedef enum logic [2:0] {
        M_LSL = 3'b000,
        M_LSR = 3'b001,
        M_ASR = 3'b010,
        M_ROL = 3'b011,
        M_ROR = 3'b100,
        M_SIL = 3'b101,
        M_SIR = 3'b110,
        M_RSV = 3'b111
    } mode_t;

`ifdef SERIAL_SHIFT_MULTISTEP_EN
    localparam int MAX_STEP = 4;
`else
    localparam int MAX_STEP = 1;
`endif

    state_t               state_q, state_d;
    mode_t                mode_q, mode_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 so_q, so_d;
    logic                 done_q, done_d;
    logic [AMT_WIDTH-1:0] count_q, count_d;

    logic [AMT_WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0]     step_q;
    logic                 step_so;
    logic [WIDTH:0]       step_tmp;

    // Returns {bit leaving the register, shifted register}.
    function automatic logic [WIDTH:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input mode_t m,
                                                 input logic fill);
        case (m)
            M_LSL:   shift_one = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            M_LSR:   shift_one = {v[0], 1'b0, v[WIDTH-1:1]};
            M_ASR:   shift_one = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            M_ROL:   shift_one = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   shift_one = {v[0], v[0], v[WIDTH-1:1]};
            M_SIL:   shift_one = {v[WIDTH-1], v[WIDTH-2:0], fill};
            M_SIR:   shift_one = {v[0], fill, v[WIDTH-1:1]};
            default: shift_one = {1'b0, v};
        endcase
    endfunction

    always_comb begin
        step_cnt = AMT_WIDTH'(1);
`ifdef SERIAL_SHIFT_MULTISTEP_EN
        if (mode_q != M_SIL && mode_q != M_SIR) begin
            if (int'(count_q) > 4) step_cnt = AMT_WIDTH'(4);
            else                   step_cnt = count_q;
        end
`endif
        step_q   = q_q;
        step_so  = so_q;
        step_tmp = '0;
        for (int i = 0; i < MAX_STEP; i++) begin
            if (i < int'(step_cnt)) begin
                step_tmp = shift_one(step_q, mode_q, serial_in);
                step_so  = step_tmp[WIDTH];
                step_q   = step_tmp[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        q_d     = q_q;
        so_d    = so_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (load) q_d = D;
                    if (start) begin
                        mode_d = mode_t'(mode);
                        if (amount != '0 && mode_t'(mode) != M_RSV) begin
                            count_d = amount;
                            state_d = ST_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // abort beats the final step: no step, no done
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        q_d     = step_q;
                        so_d    = step_so;
                        count_d = count_q - step_cnt;
                        if (count_d == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= M_LSL;
            q_q     <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign Q          = q_q;
    assign serial_out = so_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_serial_shift_engine.sv
// Directed bench for serial_shift_engine (WIDTH=8, AMT_WIDTH=4, single-step build).
module tb_serial_shift_engine;

    logic       clock, reset, en, load, start, serial_in, abort;
    logic [7:0] D;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] Q;
    logic       serial_out, busy, done;

    int n_pass  = 0;
    int n_total = 0;

    serial_shift_engine #(.WIDTH(8), .AMT_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .en(en), .load(load), .D(D),
        .start(start), .mode(mode), .amount(amount), .serial_in(serial_in),
        .abort(abort), .Q(Q), .serial_out(serial_out), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic [2:0] m;
        logic [3:0] a;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_so;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic run_op(input logic [7:0] d, input logic [2:0] m, input logic [3:0] a,
                          input logic sin, output int cyc, output logic done_end,
                          output logic done_after);
        @(negedge clock); load = 1'b1; D = d;
        @(negedge clock); load = 1'b0; start = 1'b1; mode = m; amount = a; serial_in = sin;
        @(negedge clock); start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clock);
        end
        done_end = done;
        @(negedge clock);
        done_after = done;
    endtask

    initial begin
        int   cyc;
        logic de, da;

        vecs[0] = '{8'hB4, 3'd0, 4'd3,  1'b0, 8'hA0, 1'b1};
        vecs[1] = '{8'h90, 3'd2, 4'd2,  1'b0, 8'hE4, 1'b0};
        vecs[2] = '{8'h81, 3'd4, 4'd9,  1'b0, 8'hC0, 1'b1};
        vecs[3] = '{8'hFF, 3'd1, 4'd10, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 3'd2, 4'd12, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{8'h81, 3'd3, 4'd1,  1'b0, 8'h03, 1'b1};
        vecs[6] = '{8'h01, 3'd0, 4'd15, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{8'h00, 3'd6, 4'd3,  1'b1, 8'hE0, 1'b0};
        vecs[8] = '{8'hFF, 3'd5, 4'd4,  1'b0, 8'hF0, 1'b1};
        vecs[9] = '{8'h96, 3'd3, 4'd4,  1'b0, 8'h69, 1'b1};

        reset = 1'b0; en = 1'b1; load = 1'b0; start = 1'b0; serial_in = 1'b0;
        abort = 1'b0; D = '0; mode = '0; amount = '0;
        repeat (2) @(negedge clock);
        check("rst_q", Q, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_so", serial_out, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].d, vecs[i].m, vecs[i].a, vecs[i].sin, cyc, de, da);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].a);
            check($sformatf("v%0d_done", i), de, 1);
            check($sformatf("v%0d_done_width", i), da, 0);
            check($sformatf("v%0d_q", i), Q, vecs[i].exp_q);
            check($sformatf("v%0d_so", i), serial_out, vecs[i].exp_so);
        end

        // load+start together, then a start/load attempted while busy
        @(negedge clock); load = 1'b1; D = 8'h00; start = 1'b1; mode = 3'd5; amount = 4'd2; serial_in = 1'b1;
        @(negedge clock); check("ls_busy", busy, 1);
        start = 1'b1; load = 1'b1; D = 8'hFF; mode = 3'd0; amount = 4'd5;
        @(negedge clock); check("ls_step1", Q, 8'h01);
        start = 1'b0; load = 1'b0;
        @(negedge clock);
        check("ls_q", Q, 8'h03);
        check("ls_done", done, 1);
        check("ls_busy_end", busy, 0);
        @(negedge clock);
        check("ls_no_rerun", busy, 0);
        check("ls_q_hold", Q, 8'h03);

        // zero-length ops: amount 0, then reserved mode
        start = 1'b1; mode = 3'd0; amount = 4'd0;
        @(negedge clock); start = 1'b0;
        check("z0_done", done, 1);
        check("z0_busy", busy, 0);
        check("z0_q", Q, 8'h03);
        @(negedge clock); check("z0_done_end", done, 0);
        start = 1'b1; mode = 3'd7; amount = 4'd5;
        @(negedge clock); start = 1'b0;
        check("rsv_done", done, 1);
        check("rsv_busy", busy, 0);
        @(negedge clock);
        check("rsv_done_end", done, 0);
        check("rsv_busy2", busy, 0);
        check("rsv_q", Q, 8'h03);

        // done must not stretch while en is low
        start = 1'b1; amount = 4'd0;
        @(negedge clock); start = 1'b0; check("en_done", done, 1);
        en = 1'b0;
        @(negedge clock); check("en_done_fall", done, 0);
        en = 1'b1;

        // abort after two steps
        @(negedge clock); load = 1'b1; D = 8'hFF;
        @(negedge clock); load = 1'b0; start = 1'b1; mode = 3'd1; amount = 4'd5;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        check("ab_q", Q, 8'h3F);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        abort = 1'b0;
        @(negedge clock);
        check("ab_done2", done, 0);
        check("ab_q2", Q, 8'h3F);

        // abort coinciding with the final step
        @(negedge clock); load = 1'b1; D = 8'hFF;
        @(negedge clock); load = 1'b0; start = 1'b1; mode = 3'd1; amount = 4'd2;
        @(negedge clock); start = 1'b0;
        @(negedge clock); abort = 1'b1;
        @(negedge clock);
        check("abf_q", Q, 8'h7F);
        check("abf_busy", busy, 0);
        check("abf_done", done, 0);
        abort = 1'b0;
        @(negedge clock); check("abf_done2", done, 0);

        // en low freezes a running op
        @(negedge clock); load = 1'b1; D = 8'h01;
        @(negedge clock); load = 1'b0; start = 1'b1; mode = 3'd0; amount = 4'd3;
        @(negedge clock); start = 1'b0;
        @(negedge clock); en = 1'b0;
        repeat (2) @(negedge clock);
        check("frz_q", Q, 8'h02);
        check("frz_busy", busy, 1);
        en = 1'b1;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clock);
        end
        check("frz_cycles", cyc, 2);
        check("frz_q_end", Q, 8'h08);
        check("frz_done", done, 1);

        // asynchronous reset mid-run
        @(negedge clock); load = 1'b1; D = 8'h01;
        @(negedge clock); load = 1'b0; start = 1'b1; mode = 3'd0; amount = 4'd6;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        check("ar_pre_q", Q, 8'h04);
        #2 reset = 1'b0;
        #1;
        check("ar_q", Q, 8'h00);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_so", serial_out, 0);
        @(negedge clock); reset = 1'b1;
        run_op(8'hB4, 3'd0, 4'd3, 1'b0, cyc, de, da);
        check("ar_re_cycles", cyc, 3);
        check("ar_re_q", Q, 8'hA0);
        check("ar_re_done", de, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_shift_engine.md
Name: serial_shift_engine

Overview:
- Parametrised sequential shifter; successor to the single-step shift register primitive.
- Holds a WIDTH-bit register and performs multi-position shifts and rotates under a start/busy/done handshake, one step per enabled cycle.
- Supports logical, arithmetic, rotate and serial-fill modes, with a carry-style serial output.
- Used by datapath controllers that need variable shifts without a full barrel shifter.

Parameters:
- WIDTH, 8: register width in bits; must be ≥ 2.
- AMT_WIDTH, 4: width of the shift-amount field. Amounts 0..2^AMT_WIDTH-1 are legal, including amounts ≥ WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0, Q, state, count and serial_out all hold.
- load  input  1  parallel-load request.
- D  input  WIDTH  parallel-load data.
- start  input  1  begin an operation.
- mode  input  3  operation select, sampled when start is accepted.
- amount  input  AMT_WIDTH  number of positions, sampled when start is accepted.
- serial_in  input  1  fill bit for the serial modes.
- abort  input  1  synchronous cancel of a running operation.
- Q  output  WIDTH  register contents.
- serial_out  output  1  last bit shifted or rotated out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - Q=0, serial_out=0, busy=0, done=0, count=0, state=IDLE.
  - Takes effect immediately, including mid-operation.
- Mode encoding:
  - 000 LSL: shift left, zero fill.
  - 001 LSR: shift right, zero fill.
  - 010 ASR: shift right, MSB replicated.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101 SIL: shift left, serial_in into the LSB.
  - 110 SIR: shift right, serial_in into the MSB.
  - 111: reserved; treated as a zero-length op (done pulse, Q unchanged).
  - serial_in is sampled on every step, not latched at start.
- States: IDLE and RUN. busy = (state==RUN).
- IDLE, with en=1:
  - load=1: Q<=D.
  - start=1: latch mode and amount. If amount≠0 (and mode≠111), count<=amount and go to RUN. Otherwise stay IDLE and assert done on the next cycle.
  - load and start together: Q<=D, and the operation acts on D.
- RUN, with en=1, on each edge:
  - Apply one step to Q.
  - serial_out <= the bit leaving Q: MSB for left modes, LSB for right modes. For rotates this is the wrapped bit.
  - count <= count-1.
  - When count reaches 0: return to IDLE and assert done on the following cycle.
- Latency: start accepted at edge k with amount N>0.
  - After edge k+n, Q reflects n steps.
  - busy is high from edge k to edge k+N.
  - done is high for exactly the cycle after edge k+N.
- load and start while busy are ignored; the current operation is unaffected.
- abort=1 with en=1 in RUN:
  - Go to IDLE; Q keeps its partially shifted value; no done pulse.
  - abort in IDLE has no effect.
  - If abort coincides with the final step, abort wins: the step is not applied and there is no done.
- en=0: Q, state, count and serial_out are frozen. done still deasserts at the next edge, so the pulse is never stretched.
- Amounts ≥ WIDTH:
  - Stepped literally, N cycles.
  - Logical shifts end at 0; ASR ends all-sign-bits.
  - Rotates wrap, e.g. ROR by WIDTH+1 = ROR by 1.

Optional Feature:
- Macro: SERIAL_SHIFT_MULTISTEP_EN.
- Defined:
  - Modes LSL, LSR, ASR, ROL and ROR advance min(count,4) positions per enabled cycle. count decrements by the same value.
  - Latency becomes ceil(N/4) cycles.
  - serial_out is the last bit leaving in that cycle's group.
  - SIL and SIR remain one position per cycle.
- Undefined: always one position per cycle, as specified above.

Test Plan (WIDTH=8, AMT_WIDTH=4, macro undefined):
1. Load 0xB4, LSL by 3 → busy for 3 cycles, Q=0xA0, serial_out=1, single done pulse on the 4th cycle after start.
2. Load 0x90, ASR by 2 → Q=0xE4, serial_out=0. Then ROR by 9 on 0x81 → Q=0xC0 after 9 busy cycles.
3. load+start in the same cycle with D=0x00, SIL, serial_in=1, amount 2 → Q=0x03. A further start issued while busy is ignored, and Q still ends at 0x03.
4. start with amount 0, then mode 111 with amount 5 → each gives done the next cycle, busy never high, Q unchanged.
5. Load 0xFF, LSR by 5, abort after 2 steps → Q=0x3F, busy low the next cycle, no done.
6. Drop reset mid-RUN (LSL by 6 on 0x01) → Q, busy, done and serial_out all 0 before the next clock edge. After release, IDLE accepts a new start.
